// File: rtl/multicyc_hs_mcu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, datapath selects,
// opcodes, ALU ops, and the per-state Moore control word.
package multicyc_hs_mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWR, S_MEMWB, S_RREXEC, S_RRWB,
        S_RIEXEC, S_RIWB, S_BRANCH, S_JMP, S_JAL, S_JR, S_LUI, S_TRAP
    } state_e;

    localparam logic       ADDR_PC     = 1'b0;
    localparam logic       ADDR_ALUOUT = 1'b1;
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_RS     = 1'b1;
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_BEQIMM = 2'd3;
    localparam logic [1:0] WR_RT       = 2'd0;
    localparam logic [1:0] WR_RD       = 2'd1;
    localparam logic [1:0] WR_RA       = 2'd2;
    localparam logic [1:0] WD_ALUOUT   = 2'd0;
    localparam logic [1:0] WD_MEMDATA  = 2'd1;
    localparam logic [1:0] WD_LUI      = 2'd2;
    localparam logic [1:0] WD_PCLINK   = 2'd3;
    localparam logic [1:0] PC_PLUS4    = 2'd0;
    localparam logic [1:0] PC_BRANCH   = 2'd1;
    localparam logic [1:0] PC_JMP      = 2'd2;
    localparam logic [1:0] PC_JR       = 2'd3;

    localparam logic [5:0] OP_RR    = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_ADDU = 4'h7;
    localparam logic [3:0] ALU_RR   = 4'hf;

    typedef struct packed {
        logic       mem_req;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       alu_srca_sel;
        logic [1:0] alu_srcb_sel;
        logic [3:0] aluop;
        logic       reg_we;
        logic [1:0] wreg_dst_sel;
        logic [1:0] wreg_data_sel;
        logic [1:0] nxt_pc_sel;
    } ctl_t;

    function automatic logic [3:0] ri_aluop(input logic [5:0] op);
        logic [3:0] a;
        case (op)
            OP_ADDIU: a = ALU_ADDU;
            OP_ANDI:  a = ALU_AND;
            OP_ORI:   a = ALU_OR;
            OP_XORI:  a = ALU_XOR;
            OP_SLTI:  a = ALU_SLT;
            OP_SLTIU: a = ALU_SLTU;
            default:  a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore part of the control word; IR is stable outside FETCH so opcode may refine it.
    function automatic ctl_t state_ctl(input state_e s, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;      c.mem_addr_sel = ADDR_PC;
                c.alu_srca_sel = SRCA_PC; c.alu_srcb_sel = SRCB_FOUR;
                c.aluop = ALU_ADD;     c.nxt_pc_sel = PC_PLUS4;
            end
            S_DECODE: begin
                c.alu_srca_sel = SRCA_PC; c.alu_srcb_sel = SRCB_BEQIMM; c.aluop = ALU_ADD;
            end
            S_MEMADDR: begin
                c.alu_srca_sel = SRCA_RS; c.alu_srcb_sel = SRCB_IMM; c.aluop = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1; c.mem_addr_sel = ADDR_ALUOUT;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1; c.mem_addr_sel = ADDR_ALUOUT; c.mem_we = 1'b1;
            end
            S_MEMWB: begin
                c.reg_we = 1'b1; c.wreg_dst_sel = WR_RT; c.wreg_data_sel = WD_MEMDATA;
            end
            S_RREXEC: begin
                c.alu_srca_sel = SRCA_RS; c.alu_srcb_sel = SRCB_RT; c.aluop = ALU_RR;
            end
            S_RRWB: begin
                c.reg_we = 1'b1; c.wreg_dst_sel = WR_RD; c.wreg_data_sel = WD_ALUOUT;
            end
            S_RIEXEC: begin
                c.alu_srca_sel = SRCA_RS; c.alu_srcb_sel = SRCB_IMM; c.aluop = ri_aluop(op);
            end
            S_RIWB: begin
                c.reg_we = 1'b1; c.wreg_dst_sel = WR_RT; c.wreg_data_sel = WD_ALUOUT;
            end
            S_BRANCH: begin
                c.alu_srca_sel = SRCA_RS; c.alu_srcb_sel = SRCB_RT;
                c.aluop = ALU_SUB;        c.nxt_pc_sel = PC_BRANCH;
            end
            S_JMP: c.nxt_pc_sel = PC_JMP;
            S_JAL: begin
                c.nxt_pc_sel = PC_JMP; c.reg_we = 1'b1;
                c.wreg_dst_sel = WR_RA; c.wreg_data_sel = WD_PCLINK;
            end
            S_JR:  c.nxt_pc_sel = PC_JR;
            S_LUI: begin
                c.reg_we = 1'b1; c.wreg_dst_sel = WR_RT; c.wreg_data_sel = WD_LUI;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicyc_hs_mcu_mem_wait_timer.sv
// Counts stalled memory-handshake cycles; expire_o is combinational in the last allowed
// wait cycle so the FSM can trap on the following edge unless ready arrives.
module multicyc_hs_mcu_mem_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic wait_i,
    output logic expire_o
);
    localparam int W = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (wait_i)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = wait_i && (cnt_q == LAST);

endmodule

// File: rtl/multicyc_hs_mcu.sv
// Multicycle MIPS control FSM with variable-latency memory handshake, timeout/illegal trap
// and retired-instruction counter. Moore outputs are registered; ir/pc/mdr enables are qualified.
module multicyc_hs_mcu
    import multicyc_hs_mcu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_addr_sel,
    output logic             mem_we,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             alu_srca_sel,
    output logic [1:0]       alu_srcb_sel,
    output logic [3:0]       aluop,
    output logic             reg_we,
    output logic [1:0]       wreg_dst_sel,
    output logic [1:0]       wreg_data_sel,
    output logic             pc_we,
    output logic [1:0]       nxt_pc_sel,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_instr,
    output logic             mem_timeout
);
    state_e           state_q, state_d;
    ctl_t             ctl_q;
    logic             illegal_q, timeout_q;
    logic [CNT_W-1:0] count_q;
    logic             illegal_set, expire, retire, entering_mem, timer_clr, mem_wait;

    assign mem_wait     = ctl_q.mem_req && !mem_ready;
    assign entering_mem = (state_d != state_q) &&
                          (state_d inside {S_FETCH, S_MEMRD, S_MEMWR});
    assign timer_clr    = entering_mem || (ctl_q.mem_req && mem_ready);

    multicyc_hs_mcu_mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (timer_clr),
        .wait_i   (mem_wait),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE; else if (expire) state_d = S_TRAP;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADDR;
                    OP_RR:          state_d = (funct == FUNCT_JR) ? S_JR : S_RREXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JMP;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
                                    state_d = S_RIEXEC;
                    OP_LUI:         state_d = S_LUI;
                    default: begin
                        state_d     = S_TRAP;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB; else if (expire) state_d = S_TRAP;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH; else if (expire) state_d = S_TRAP;
            S_RREXEC:  state_d = S_RRWB;
            S_RIEXEC:  state_d = S_RIWB;
            S_MEMWB, S_RRWB, S_RIWB, S_BRANCH, S_JMP, S_JAL, S_JR, S_LUI:
                       state_d = S_FETCH;
            default:   state_d = state_q;
        endcase
    end

    // Any arrival in FETCH from another state is the last cycle of an instruction.
    assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctl_q     <= state_ctl(S_FETCH, OP_RR);
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= state_ctl(state_d, opcode);
            if (illegal_set) illegal_q <= 1'b1;
            if (expire)      timeout_q <= 1'b1;
            if (retire)      count_q   <= count_q + CNT_W'(1);
        end
    end

    assign ir_we  = (state_q == S_FETCH) && mem_ready;
    assign mdr_we = (state_q == S_MEMRD) && mem_ready;
    assign pc_we  = ir_we
                 || ((state_q == S_BRANCH) && ((opcode == OP_BNE) ? !alu_zero : alu_zero))
                 || (state_q inside {S_JMP, S_JAL, S_JR});

    assign mem_req       = ctl_q.mem_req;
    assign mem_addr_sel  = ctl_q.mem_addr_sel;
    assign mem_we        = ctl_q.mem_we;
    assign alu_srca_sel  = ctl_q.alu_srca_sel;
    assign alu_srcb_sel  = ctl_q.alu_srcb_sel;
    assign aluop         = ctl_q.aluop;
    assign reg_we        = ctl_q.reg_we;
    assign wreg_dst_sel  = ctl_q.wreg_dst_sel;
    assign wreg_data_sel = ctl_q.wreg_data_sel;
    assign nxt_pc_sel    = ctl_q.nxt_pc_sel;
    assign instr_done    = retire;
    assign instr_count   = count_q;
    assign illegal_instr = illegal_q;
    assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_multicyc_hs_mcu.sv
// Directed + randomized instruction streams checked cycle-by-cycle against a per-step
// expectation table and a modular retire-count model.
module tb_multicyc_hs_mcu;
    import multicyc_hs_mcu_pkg::*;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = '0, funct = '0;
    logic          alu_zero = 1'b0, mem_ready = 1'b0;
    logic          mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, alu_srca_sel;
    logic [1:0]    alu_srcb_sel, wreg_dst_sel, wreg_data_sel, nxt_pc_sel;
    logic [3:0]    aluop;
    logic          reg_we, pc_we, instr_done, illegal_instr, mem_timeout;
    logic [CW-1:0] instr_count;

    int compared = 0;
    int mismatched = 0;
    int model_cnt = 0;

    multicyc_hs_mcu #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
        .mem_we(mem_we), .ir_we(ir_we), .mdr_we(mdr_we), .alu_srca_sel(alu_srca_sel),
        .alu_srcb_sel(alu_srcb_sel), .aluop(aluop), .reg_we(reg_we),
        .wreg_dst_sel(wreg_dst_sel), .wreg_data_sel(wreg_data_sel), .pc_we(pc_we),
        .nxt_pc_sel(nxt_pc_sel), .instr_done(instr_done), .instr_count(instr_count),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    logic [20:0] obs_vec;
    assign obs_vec = {mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, alu_srca_sel, alu_srcb_sel,
                      aluop, reg_we, wreg_dst_sel, wreg_data_sel, pc_we, nxt_pc_sel, instr_done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expected outputs of one cycle of a named instruction step, straight from the step table.
    function automatic logic [20:0] exp_vec(input string s, input logic [5:0] op,
                                            input logic rdy, input logic zero, input logic ret);
        logic req, addr, we, irwe, mdrwe, srca, regwe, pcwe;
        logic [1:0] srcb, dst, wd, nxt;
        logic [3:0] aop;
        {req, addr, we, irwe, mdrwe, srca, regwe, pcwe} = '0;
        {srcb, dst, wd, nxt, aop} = '0;
        case (s)
            "F":   begin req = 1; srcb = 2'd1; aop = ALU_ADD; irwe = rdy; pcwe = rdy; end
            "D":   begin srcb = 2'd3; aop = ALU_ADD; end
            "MA":  begin srca = 1; srcb = 2'd2; aop = ALU_ADD; end
            "RD":  begin req = 1; addr = 1; mdrwe = rdy; end
            "WR":  begin req = 1; addr = 1; we = 1; end
            "WB":  begin regwe = 1; wd = 2'd1; end
            "RX":  begin srca = 1; aop = ALU_RR; end
            "RW":  begin regwe = 1; dst = 2'd1; end
            "IX": begin
                srca = 1; srcb = 2'd2;
                case (op)
                    OP_ADDI:  aop = ALU_ADD;
                    OP_ADDIU: aop = ALU_ADDU;
                    OP_ANDI:  aop = ALU_AND;
                    OP_ORI:   aop = ALU_OR;
                    OP_XORI:  aop = ALU_XOR;
                    OP_SLTI:  aop = ALU_SLT;
                    default:  aop = ALU_SLTU;
                endcase
            end
            "IW":  regwe = 1;
            "BR":  begin srca = 1; aop = ALU_SUB; nxt = 2'd1; pcwe = (op == OP_BNE) ? !zero : zero; end
            "J":   begin pcwe = 1; nxt = 2'd2; end
            "JAL": begin pcwe = 1; nxt = 2'd2; regwe = 1; dst = 2'd2; wd = 2'd3; end
            "JR":  begin pcwe = 1; nxt = 2'd3; end
            "LUI": begin regwe = 1; wd = 2'd2; end
            default: ;
        endcase
        return {req, addr, we, irwe, mdrwe, srca, srcb, aop, regwe, dst, wd, pcwe, nxt, ret};
    endfunction

    // Entered and left at a falling edge; the DUT advances on the rising edge in between.
    task automatic step(input string s, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic zero, input logic ret);
        opcode = op; funct = fn; mem_ready = rdy; alu_zero = zero;
        #1;
        chk({"ctl_", s}, 32'(obs_vec), 32'(exp_vec(s, op, rdy, zero, ret)));
        if (ret) model_cnt = (model_cnt + 1) % (1 << CW);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int fw, input int mw);
        for (int i = 0; i <= fw; i++) step("F", op, fn, i == fw, rb(), 0);
        step("D", op, fn, rb(), rb(), 0);
        case (op)
            OP_LW: begin
                step("MA", op, fn, rb(), rb(), 0);
                for (int i = 0; i <= mw; i++) step("RD", op, fn, i == mw, rb(), 0);
                step("WB", op, fn, rb(), rb(), 1);
            end
            OP_SW: begin
                step("MA", op, fn, rb(), rb(), 0);
                for (int i = 0; i <= mw; i++) step("WR", op, fn, i == mw, rb(), i == mw);
            end
            OP_RR: begin
                if (fn == FUNCT_JR) step("JR", op, fn, rb(), rb(), 1);
                else begin
                    step("RX", op, fn, rb(), rb(), 0);
                    step("RW", op, fn, rb(), rb(), 1);
                end
            end
            OP_BEQ, OP_BNE: step("BR", op, fn, rb(), zero, 1);
            OP_J:   step("J", op, fn, rb(), rb(), 1);
            OP_JAL: step("JAL", op, fn, rb(), rb(), 1);
            OP_LUI: step("LUI", op, fn, rb(), rb(), 1);
            default: begin
                step("IX", op, fn, rb(), rb(), 0);
                step("IW", op, fn, rb(), rb(), 1);
            end
        endcase
        chk("instr_count", 32'(instr_count), 32'(model_cnt));
        chk("flags", {30'd0, illegal_instr, mem_timeout}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
    endtask

    logic [5:0] ops [15] = '{OP_LW, OP_SW, OP_RR, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI,
                             OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI};

    initial begin
        do_reset();
        #1;
        chk("rst_ctl", 32'(obs_vec), 32'(exp_vec("F", 6'h00, 1'b0, 1'b0, 1'b0)));
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_flags", {30'd0, illegal_instr, mem_timeout}, 32'd0);

        // LW with ready in the 4th cycle of FETCH and MEMRD: the ready-wins boundary.
        run_instr(OP_LW, 6'h00, 1'b0, 3, 3);
        chk("lw_count", 32'(instr_count), 32'd1);
        run_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
        run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
        run_instr(OP_JAL, 6'h00, 1'b0, 1, 0);
        run_instr(OP_RR, FUNCT_JR, 1'b0, 0, 0);
        run_instr(OP_SW, 6'h00, 1'b0, 0, 2);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 14)];
            fn = ($urandom_range(0, 3) == 0) ? FUNCT_JR : 6'($urandom_range(0, 63));
            run_instr(op, fn, rb(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end

        // Counter wrap: 16 retires on a 4-bit counter return to zero.
        do_reset();
        for (int n = 0; n < 15; n++) run_instr(OP_J, 6'h00, 1'b0, 0, 0);
        chk("pre_wrap", 32'(instr_count), 32'd15);
        run_instr(OP_J, 6'h00, 1'b0, 0, 0);
        chk("wrap", 32'(instr_count), 32'd0);

        // FETCH timeout.
        do_reset();
        for (int i = 0; i < TO; i++) step("F", OP_LW, 6'h00, 1'b0, 1'b0, 0);
        step("TRAP", OP_LW, 6'h00, 1'b1, 1'b0, 0);
        step("TRAP", OP_LW, 6'h00, 1'b1, 1'b1, 0);
        chk("fetch_to_flags", {30'd0, illegal_instr, mem_timeout}, 32'd1);
        chk("fetch_to_count", 32'(instr_count), 32'd0);

        // MEMRD timeout.
        do_reset();
        step("F", OP_LW, 6'h00, 1'b1, 1'b0, 0);
        step("D", OP_LW, 6'h00, 1'b0, 1'b0, 0);
        step("MA", OP_LW, 6'h00, 1'b0, 1'b0, 0);
        for (int i = 0; i < TO; i++) step("RD", OP_LW, 6'h00, 1'b0, 1'b0, 0);
        step("TRAP", OP_LW, 6'h00, 1'b1, 1'b0, 0);
        chk("rd_to_flags", {30'd0, illegal_instr, mem_timeout}, 32'd1);

        // Illegal opcode.
        do_reset();
        step("F", 6'h3f, 6'h00, 1'b1, 1'b0, 0);
        step("D", 6'h3f, 6'h00, 1'b0, 1'b0, 0);
        step("TRAP", 6'h3f, 6'h00, 1'b1, 1'b0, 0);
        chk("illegal_flags", {30'd0, illegal_instr, mem_timeout}, 32'd2);
        chk("illegal_count", 32'(instr_count), 32'd0);

        // Reset asserted mid-MEMWR.
        do_reset();
        run_instr(OP_J, 6'h00, 1'b0, 0, 0);
        step("F", OP_SW, 6'h00, 1'b1, 1'b0, 0);
        step("D", OP_SW, 6'h00, 1'b0, 1'b0, 0);
        step("MA", OP_SW, 6'h00, 1'b0, 1'b0, 0);
        step("WR", OP_SW, 6'h00, 1'b0, 1'b0, 0);
        mem_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midwr_ctl", 32'(obs_vec), 32'(exp_vec("F", OP_SW, 1'b0, 1'b0, 1'b0)));
        chk("midwr_count", 32'(instr_count), 32'd0);
        chk("midwr_flags", {30'd0, illegal_instr, mem_timeout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        run_instr(OP_ADDI, 6'h00, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
